rbm_batch_sequencer: RTL and testbench
======================================

Name: rbm_batch_sequencer

Overview:
- Batch front-end for the RBM top (Main): buffers up to `batch_depth` input vectors and runs them through Main back to back.
- Per vector, it pulses Main's reset, holds `data_valid`, detects the rising edge of `finish`, and captures the output vector.
- Returns each result over a valid/ready handshake.
- Generalises the single-image, single-shot stimulus flow to a parametrised, multi-vector, back-pressured sequencer.

Parameters:
- bitlength, 12, fixed-point word width
- input_dim, 4, words per input vector (64 for sparse builds)
- output_dim, 2, words per RBM output vector
- batch_depth, 8, input buffer depth in vectors (power of 2, ≥2)
- rbm_reset_cycles, 3, cycles the Main reset is held per vector (≥1)
- timeout_cycles, 4096, watchdog limit (used only with RBM_TIMEOUT_EN)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- vec_wr_en  in  1  write one input vector into the buffer
- vec_wr_data  in  input_dim*bitlength  packed input vector; word i at [i*bitlength +: bitlength]
- start  in  1  single-cycle pulse: process every buffered vector
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the batch completes
- overflow  out  1  sticky: a write was dropped; cleared by start
- rbm_reset  out  1  active-high reset to Main
- rbm_data_valid  out  1  data_valid to Main
- rbm_input_port  out  input_dim*bitlength  current vector to Main
- rbm_output_port  in  output_dim*bitlength  Main output
- rbm_finish  in  1  Main finish
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_data  out  output_dim*bitlength  captured Main output
- res_index  out  $clog2(batch_depth)  buffer slot that produced the result
- timeout_err  out  1  sticky watchdog flag; cleared by start (RBM_TIMEOUT_EN only, otherwise tied to 0)

Behaviour:
- Reset values: all outputs 0, state IDLE, buffer pointers and count 0. Buffer contents are not reset.
- Input buffer:
  - Writes are accepted only in IDLE while count < batch_depth. Each accepted write stores at wr_ptr, then wr_ptr wraps modulo batch_depth and count increments.
  - A write when full, or while not IDLE, is dropped and sets overflow.
- start in IDLE:
  - If count == 0: done pulses next cycle, busy stays 0.
  - Otherwise: rd_ptr = wr_ptr - count (mod batch_depth), busy = 1, go to RST.
  - start is ignored outside IDLE.
- RST: rbm_reset = 1 and rbm_data_valid = 0 for exactly rbm_reset_cycles cycles. rbm_input_port is driven from buffer[rd_ptr]. Then go to RUN.
- RUN:
  - rbm_data_valid = 1 and rbm_input_port is held stable.
  - Finish detection is the rising edge of rbm_finish, registered as finish && !finish_q. A level that is already high on entry to RUN does not count.
  - On the edge: rbm_data_valid = 0, capture rbm_output_port into res_data and rd_ptr into res_index, go to HOLD.
- HOLD:
  - res_valid = 1. res_data and res_index stay stable until res_valid && res_ready, and that transfer completes in that cycle.
  - On the transfer: count decrements and rd_ptr wraps forward. Then go to RST if count > 0, else DONE.
- DONE: done = 1 for one cycle, busy = 0, return to IDLE.
- Latency:
  - Start to first rbm_data_valid is 1 + rbm_reset_cycles.
  - RBM finish edge to res_valid is 2 cycles (edge register, then capture).
- rbm_reset is registered and glitch-free. Asserting reset at any point aborts the batch: buffer emptied, rbm_reset = 0.

Optional Feature:
- RBM_TIMEOUT_EN defined:
  - A counter runs in RUN. Reaching timeout_cycles without a finish edge sets timeout_err.
  - The sequencer then emits a result with res_data = all-ones and res_index = rd_ptr, and continues normally.
- RBM_TIMEOUT_EN undefined: no counter, timeout_err tied to 0, RUN waits indefinitely.

Decomposition:
- Shared include with config.v:
  - state encodings IDLE/RST/RUN/HOLD/DONE
  - the packed-port slicing macro
  - the all-ones error-word constant
- One natural sub-module: rbm_vec_buffer (circular vector RAM with wr_ptr, rd_ptr, count, full/empty, overflow detection). The FSM stays in the top.

Test Plan:
- Bench stub models Main: latches the input, returns word0+word1 and word2+word3, raises finish 5 cycles after data_valid.
- Load 3 vectors {1,2,3,4},{5,6,7,8},{0x7FF,1,0,0}, then start, res_ready = 1 → results (3,7),(11,15),(0x800,0) with res_index 0,1,2. done pulses after the third; rbm_reset asserts 3 cycles before each vector.
- Write 9 vectors with batch_depth = 8 → overflow = 1, count 8. Start → 8 results in order and overflow cleared.
- Hold res_ready = 0 for 20 cycles after the first result → res_data stable, rbm_data_valid stays 0, no second vector issued until the transfer.
- start with an empty buffer → done one cycle later, busy never high, rbm_reset never asserted.
- Stub never raises finish, RBM_TIMEOUT_EN defined, timeout_cycles = 16 → timeout_err after 16 RUN cycles, result 0xFFF/0xFFF, batch continues. Assert reset mid-RUN → all outputs 0 asynchronously.

Source files
------------

// File: rtl/rbm_batch_sequencer_pkg.sv
// rtl/rbm_batch_sequencer_pkg.sv - shared state encoding and sizing helper for the RBM batch sequencer
package rbm_batch_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RST  = 3'd1,
        ST_RUN  = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } seq_state_t;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rbm_vec_buffer.sv
// rtl/rbm_vec_buffer.sv - circular input-vector RAM with pointers, occupancy and sticky overflow
module rbm_vec_buffer
    import rbm_batch_sequencer_pkg::*;
#(
    parameter int unsigned width = 48,
    parameter int unsigned depth = 8,
    localparam int unsigned PW = ptr_width(depth)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [width-1:0] wr_data,
    input  logic             wr_allow,
    input  logic             load_rd,
    input  logic             pop,
    input  logic             clear_ovf,
    output logic [width-1:0] rd_data,
    output logic [PW-1:0]    rd_ptr,
    output logic [PW:0]      count,
    output logic             empty,
    output logic             overflow
);

    logic [width-1:0] mem [depth];
    logic [PW-1:0]    wr_ptr;
    logic             full;
    logic             wr_ok;

    assign full    = (count == (PW+1)'(depth));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && wr_allow && !full;
    assign rd_data = mem[rd_ptr];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            // Oldest slot sits count entries behind the write pointer; depth is a power of two.
            if (load_rd) begin
                rd_ptr <= wr_ptr - count[PW-1:0];
            end else if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_ok, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (wr_en && !wr_ok) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rbm_batch_sequencer.sv
// rtl/rbm_batch_sequencer.sv - batch front-end running buffered vectors through the RBM core; RBM_TIMEOUT_EN adds a RUN watchdog
module rbm_batch_sequencer
    import rbm_batch_sequencer_pkg::*;
#(
    parameter int unsigned bitlength        = 12,
    parameter int unsigned input_dim        = 4,
    parameter int unsigned output_dim       = 2,
    parameter int unsigned batch_depth      = 8,
    parameter int unsigned rbm_reset_cycles = 3,
    parameter int unsigned timeout_cycles   = 4096,
    localparam int unsigned IW = input_dim * bitlength,
    localparam int unsigned OW = output_dim * bitlength,
    localparam int unsigned PW = ptr_width(batch_depth)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          vec_wr_en,
    input  logic [IW-1:0] vec_wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic          rbm_reset,
    output logic          rbm_data_valid,
    output logic [IW-1:0] rbm_input_port,
    input  logic [OW-1:0] rbm_output_port,
    input  logic          rbm_finish,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [OW-1:0] res_data,
    output logic [PW-1:0] res_index,
    output logic          timeout_err
);

    localparam int unsigned CW = ptr_width(rbm_reset_cycles);
    localparam logic [CW-1:0] RST_LAST = CW'(rbm_reset_cycles - 1);

    if (batch_depth < 2 || (batch_depth & (batch_depth - 1)) != 0 ||
        rbm_reset_cycles < 1 || timeout_cycles < 1) begin : g_bad_cfg
        $error("rbm_batch_sequencer: invalid parameter set");
    end

    seq_state_t    state, state_n;
    logic [CW-1:0] rst_cnt;
    logic          finish_q;
    logic          edge_q;
    logic          start_ok;
    logic          buf_load, buf_pop;
    logic          cap_ok, cap_err;
    logic [IW-1:0] buf_rd_data;
    logic [PW-1:0] buf_rd_ptr;
    logic [PW:0]   buf_count;
    logic          buf_empty;

`ifdef RBM_TIMEOUT_EN
    localparam int unsigned TW = ptr_width(timeout_cycles);
    localparam logic [TW-1:0] TO_LAST = TW'(timeout_cycles - 1);
    logic [TW-1:0] to_cnt;
`endif

    assign start_ok = start && (state == ST_IDLE);

    rbm_vec_buffer #(
        .width (IW),
        .depth (batch_depth)
    ) u_buf (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (vec_wr_en),
        .wr_data   (vec_wr_data),
        .wr_allow  (state == ST_IDLE),
        .load_rd   (buf_load),
        .pop       (buf_pop),
        .clear_ovf (start_ok),
        .rd_data   (buf_rd_data),
        .rd_ptr    (buf_rd_ptr),
        .count     (buf_count),
        .empty     (buf_empty),
        .overflow  (overflow)
    );

    always_comb begin
        state_n  = state;
        buf_load = 1'b0;
        buf_pop  = 1'b0;
        cap_ok   = 1'b0;
        cap_err  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n  = buf_empty ? ST_DONE : ST_RST;
                    buf_load = !buf_empty;
                end
            end
            ST_RST: begin
                if (rst_cnt == RST_LAST) begin
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                if (edge_q) begin
                    state_n = ST_HOLD;
                    cap_ok  = 1'b1;
                end
`ifdef RBM_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    state_n = ST_HOLD;
                    cap_err = 1'b1;
                end
`endif
            end
            ST_HOLD: begin
                // res_valid is always high here, so ready alone completes the transfer.
                if (res_ready) begin
                    buf_pop = 1'b1;
                    state_n = (buf_count > (PW+1)'(1)) ? ST_RST : ST_DONE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Every external control is a flop loaded from the next state, so none can glitch.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            rst_cnt        <= '0;
            finish_q       <= 1'b0;
            edge_q         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            rbm_reset      <= 1'b0;
            rbm_data_valid <= 1'b0;
            rbm_input_port <= '0;
            res_valid      <= 1'b0;
            res_data       <= '0;
            res_index      <= '0;
        end else begin
            state          <= state_n;
            rst_cnt        <= (state == ST_RST && state_n == ST_RST) ? rst_cnt + CW'(1) : '0;
            finish_q       <= rbm_finish;
            // Gated by RUN so a finish level carried in from before RUN is never taken as an edge.
            edge_q         <= (state == ST_RUN) && rbm_finish && !finish_q;
            busy           <= (state_n == ST_RST) || (state_n == ST_RUN) || (state_n == ST_HOLD);
            done           <= (state_n == ST_DONE);
            rbm_reset      <= (state_n == ST_RST);
            rbm_data_valid <= (state_n == ST_RUN);
            res_valid      <= (state_n == ST_HOLD);
            if (state == ST_RST) begin
                rbm_input_port <= buf_rd_data;
            end
            if (cap_ok) begin
                res_data  <= rbm_output_port;
                res_index <= buf_rd_ptr;
            end else if (cap_err) begin
                res_data  <= '1;
                res_index <= buf_rd_ptr;
            end
        end
    end

`ifdef RBM_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            to_cnt <= (state == ST_RUN && state_n == ST_RUN) ? to_cnt + TW'(1) : '0;
            if (cap_err) begin
                timeout_err <= 1'b1;
            end else if (start_ok) begin
                timeout_err <= 1'b0;
            end
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_rbm_batch_sequencer.sv
// tb/tb_rbm_batch_sequencer.sv - self-checking bench for rbm_batch_sequencer with a stub RBM core
module tb_rbm_batch_sequencer;

    localparam int BL = 12;
    localparam int ID = 4;
    localparam int OD = 2;
    localparam int BD = 8;
    localparam int RC = 3;
    localparam int TO = 16;
    localparam int IW = ID * BL;
    localparam int OW = OD * BL;
    localparam int PW = $clog2(BD);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          vec_wr_en = 1'b0;
    logic [IW-1:0] vec_wr_data = '0;
    logic          start = 1'b0;
    logic          busy, done, overflow;
    logic          rbm_reset, rbm_data_valid;
    logic [IW-1:0] rbm_input_port;
    logic [OW-1:0] rbm_output_port = '0;
    logic          rbm_finish = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [OW-1:0] res_data;
    logic [PW-1:0] res_index;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    rbm_batch_sequencer #(
        .bitlength        (BL),
        .input_dim        (ID),
        .output_dim       (OD),
        .batch_depth      (BD),
        .rbm_reset_cycles (RC),
        .timeout_cycles   (TO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .vec_wr_en       (vec_wr_en),
        .vec_wr_data     (vec_wr_data),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .overflow        (overflow),
        .rbm_reset       (rbm_reset),
        .rbm_data_valid  (rbm_data_valid),
        .rbm_input_port  (rbm_input_port),
        .rbm_output_port (rbm_output_port),
        .rbm_finish      (rbm_finish),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_data        (res_data),
        .res_index       (res_index),
        .timeout_err     (timeout_err)
    );

    // Stub RBM core: sums word pairs and raises finish on the fifth valid cycle.
    logic stub_mute = 1'b0;
    int   stub_cnt = 0;
    always @(posedge clock) begin
        if (rbm_reset) begin
            stub_cnt   <= 0;
            rbm_finish <= 1'b0;
        end else if (rbm_data_valid && !rbm_finish && !stub_mute) begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt == 4) begin
                rbm_finish      <= 1'b1;
                rbm_output_port <= {rbm_input_port[2*BL +: BL] + rbm_input_port[3*BL +: BL],
                                    rbm_input_port[0 +: BL] + rbm_input_port[BL +: BL]};
            end
        end
    end

    typedef struct {
        logic [IW-1:0] vec;
        int            slot;
    } ent_t;

    ent_t mq[$];
    int   m_wr = 0;
    bit   m_ovf = 0;
    bit   m_timeout = 0;

    function automatic logic [63:0] model_out(input logic [IW-1:0] v);
        int w [ID];
        for (int i = 0; i < ID; i++) w[i] = int'((v >> (i * BL)) & 48'hFFF);
        return 64'(((w[2] + w[3]) % 4096) * 4096 + ((w[0] + w[1]) % 4096));
    endfunction

    function automatic logic [IW-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [IW-1:0] v;
        v = {BL'(d), BL'(c), BL'(b), BL'(a)};
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_vec(input logic [IW-1:0] v);
        @(negedge clock);
        vec_wr_en   = 1'b1;
        vec_wr_data = v;
        if (mq.size() < BD) begin
            mq.push_back('{v, m_wr});
            m_wr = (m_wr + 1) % BD;
        end else begin
            m_ovf = 1;
        end
        @(negedge clock);
        vec_wr_en = 1'b0;
    endtask

    task automatic run_batch(input int ready_pct, input bit stall_first);
        int  n_exp, n_got, first_dv, rst_run, dv_run, fin_cyc, hold;
        bit  dv_prev, fin_prev, rv_prev, done_seen;
        logic [63:0] exp_d;
        n_exp = mq.size(); n_got = 0; first_dv = -1; rst_run = 0; dv_run = 0;
        fin_cyc = -1000; hold = 0; dv_prev = 0; fin_prev = 0; rv_prev = 0; done_seen = 0;
        @(negedge clock);
        start = 1'b1;
        m_ovf = 0;
        for (int cyc = 1; cyc <= 3000 && !done_seen; cyc++) begin
            @(negedge clock);
            start     = 1'b0;
            res_ready = 1'b0;
            if (rbm_reset) rst_run++;
            if (rbm_data_valid) dv_run++;
            if (rbm_data_valid && !dv_prev) begin
                check("rst_len", rst_run, RC);
                rst_run = 0;
                dv_run  = 1;
                if (first_dv < 0) begin
                    first_dv = cyc;
                    check("start_to_dv", cyc, 1 + RC);
                    check("busy_run", busy, 1);
                end
            end
            if (rbm_finish && !fin_prev) fin_cyc = cyc;
            if (res_valid && !rv_prev) begin
                if (m_timeout) begin
                    check("to_run_cycles", dv_run, TO);
                    check("to_err", timeout_err, 1);
                end else begin
                    check("fin_to_res", cyc - fin_cyc, 2);
                end
            end
            if (res_valid) begin
                if (mq.size() == 0) begin
                    check("extra_result", 1, 0);
                    res_ready = 1'b1;
                end else begin
                    exp_d = m_timeout ? 64'hFFFFFF : model_out(mq[0].vec);
                    if (stall_first && n_got == 0 && hold < 20) begin
                        hold++;
                        check("stall_data", res_data, exp_d);
                        check("stall_dv", rbm_data_valid, 0);
                        check("stall_rst", rbm_reset, 0);
                    end else if ($urandom_range(99, 0) < ready_pct) begin
                        check("res_data", res_data, exp_d);
                        check("res_index", res_index, mq[0].slot);
                        res_ready = 1'b1;
                        void'(mq.pop_front());
                        n_got++;
                    end
                end
            end
            if (done) begin
                done_seen = 1;
                check("done_count", n_got, n_exp);
                check("done_busy", busy, 0);
            end
            dv_prev  = rbm_data_valid;
            fin_prev = rbm_finish;
            rv_prev  = res_valid;
        end
        if (!done_seen) check("batch_no_done", 0, 1);
        check("overflow_after", overflow, m_ovf);
    endtask

    task automatic empty_start(input string tag);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rst"}, rbm_reset, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check({tag, "_busy_after"}, busy, 0);
            check({tag, "_rst_after"}, rbm_reset, 0);
            check({tag, "_done_after"}, done, 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_rbm_rst"}, rbm_reset, 0);
        check({tag, "_dv"}, rbm_data_valid, 0);
        check({tag, "_inport"}, rbm_input_port, 0);
        check({tag, "_rvalid"}, res_valid, 0);
        check({tag, "_rdata"}, res_data, 0);
        check({tag, "_rindex"}, res_index, 0);
        check({tag, "_to_err"}, timeout_err, 0);
    endtask

    initial begin
        bit got_dv;
        int n;

        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clock);

        empty_start("empty");

        write_vec(pack4(1, 2, 3, 4));
        write_vec(pack4(5, 6, 7, 8));
        write_vec(pack4(12'h7FF, 1, 0, 0));
        run_batch(100, 0);

        for (int i = 0; i < 9; i++) write_vec(IW'({$urandom, $urandom}));
        check("overflow_set", overflow, m_ovf);
        check("overflow_model", m_ovf, 1);
        run_batch(100, 0);

        write_vec(IW'({$urandom, $urandom}));
        write_vec(IW'({$urandom, $urandom}));
        run_batch(100, 1);

        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(BD, 1);
            for (int i = 0; i < n; i++) write_vec(IW'({$urandom, $urandom}));
            run_batch(60, 0);
        end

`ifdef RBM_TIMEOUT_EN
        stub_mute = 1'b1;
        m_timeout = 1;
        write_vec(IW'({$urandom, $urandom}));
        write_vec(IW'({$urandom, $urandom}));
        run_batch(100, 0);
        check("to_sticky", timeout_err, 1);
        stub_mute = 1'b0;
        m_timeout = 0;
        write_vec(pack4(9, 9, 9, 9));
        run_batch(100, 0);
        check("to_cleared", timeout_err, 0);
`endif

        // Abort mid-RUN: a write while busy sets overflow, then async reset clears everything.
        write_vec(pack4(3, 3, 3, 3));
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start     = 1'b0;
        vec_wr_en = 1'b1;
        @(negedge clock);
        vec_wr_en = 1'b0;
        check("busy_write_ovf", overflow, 1);
        got_dv = 0;
        for (int i = 0; i < 50 && !got_dv; i++) begin
            @(negedge clock);
            got_dv = rbm_data_valid;
        end
        check("abort_reached_run", got_dv, 1);
        #2 reset = 1'b0;
        #1 check_all_zero("abort");
        @(negedge clock);
        reset = 1'b1;
        mq.delete();
        m_wr  = 0;
        m_ovf = 0;
        empty_start("post_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
